// File: rtl/alu_mdu_seq.sv
// Registered execute-stage ALU with an iterative multiply/divide unit.
// Single-cycle ops finish in one edge; MULT/DIV run WIDTH+2 cycles into HI/LO.
module alu_mdu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [4:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   Shamt,
    output logic             Busy,
    output logic             Done,
    output logic             Zero,
    output logic             Overflow,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       dbg_state
);

    // Handshake: Start is accepted only while Busy is low (state IDLE); the
    // accepting edge samples all operands, and Done pulses for one cycle
    // when ALUResult (single-cycle ops) or HI/LO (multiply/divide) are valid.

    localparam logic [4:0] OP_SLL  = 5'd0;
    localparam logic [4:0] OP_SRL  = 5'd1;
    localparam logic [4:0] OP_LUI  = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_NOR  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_XOR  = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_SLT  = 5'd11;
    localparam logic [4:0] OP_SLTU = 5'd12;
    localparam logic [4:0] OP_MFHI = 5'd13;
    localparam logic [4:0] OP_MFLO = 5'd14;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic accept, is_mdu, mdu_start, alu_start;
    logic sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ov;

    logic             op_mul, neg_q, neg_r, dz;
    logic [WIDTH-1:0] opnd, acc_hi, acc_lo;
    logic [SHW-1:0]   cnt;

    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign accept    = Start && (state == IDLE);
    assign is_mdu    = (ALUOperation[4:2] == 3'b100);
    assign mdu_start = accept && is_mdu;
    assign alu_start = accept && !is_mdu;

    assign Busy      = (state != IDLE);
    assign dbg_state = state;

    // Codes 16/18 are the signed variants; work on magnitudes and fix signs at the end.
    assign sgn_op = !ALUOperation[0];
    assign a_neg  = sgn_op && A[WIDTH-1];
    assign b_neg  = sgn_op && B[WIDTH-1];
    assign a_mag  = a_neg ? (~A + 1'b1) : A;
    assign b_mag  = b_neg ? (~B + 1'b1) : B;

    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (ALUOperation)
            OP_SLL:  alu_res = B << Shamt;
            OP_SRL:  alu_res = B >> Shamt;
            OP_LUI:  alu_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_ADD: begin
                alu_res = sum;
                alu_ov  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ov  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_NOR:  alu_res = ~(A | B);
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SRA:  alu_res = $unsigned($signed(B) >>> Shamt);
            OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
            OP_SLTU: alu_res = WIDTH'(A < B);
            OP_MFHI: alu_res = HI;
            OP_MFLO: alu_res = LO;
            default: alu_res = '0;
        endcase
    end

    // Multiply: acc_lo holds the multiplier and shifts right as product bits enter.
    // Divide: {acc_hi, acc_lo} is {remainder, dividend/quotient}, restoring.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_sub   = div_shift[WIDTH-1:0] - opnd;

    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        if (op_mul) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end
    end

    assign prod_neg = ~{acc_hi, acc_lo} + 1'b1;

    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (op_mul) begin
            if (neg_q) begin
                fix_hi = prod_neg[2*WIDTH-1:WIDTH];
                fix_lo = prod_neg[WIDTH-1:0];
            end
        end else begin
            fix_hi = neg_r ? (~acc_hi + 1'b1) : acc_hi;
            if (dz) begin
                fix_lo = '1;
            end else if (neg_q) begin
                fix_lo = ~acc_lo + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mdu_start) state_next = ITER;
            ITER:    if (cnt == CNT_LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Done      <= 1'b0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            ALUResult <= '0;
            HI        <= '0;
            LO        <= '0;
            op_mul    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
        end else begin
            Done <= 1'b0;
            if (alu_start) begin
                ALUResult <= alu_res;
                Zero      <= (alu_res == '0);
                Overflow  <= alu_ov;
                Done      <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mdu_start) begin
                        op_mul <= !ALUOperation[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= (B == '0);
                        opnd   <= ALUOperation[1] ? b_mag : a_mag;
                        acc_lo <= ALUOperation[1] ? a_mag : b_mag;
                        acc_hi <= '0;
                        cnt    <= '0;
                    end
                end
                ITER: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                end
                FIX: begin
                    HI   <= fix_hi;
                    LO   <= fix_lo;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: single-cycle ops, MULT/DIV latency and
// results, Start-while-busy, reset mid-operation, and a WIDTH=16 instance.
module tb_alu_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        Busy, Done, Zero, Overflow;
    logic [31:0] ALUResult, HI, LO;
    logic [1:0]  dbg_state;

    logic        s_start;
    logic [4:0]  s_op;
    logic [15:0] s_a, s_b;
    logic [3:0]  s_sh;
    logic        s_busy, s_done, s_zero, s_ovf;
    logic [15:0] s_res, s_hi, s_lo;
    logic [1:0]  s_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ALUOperation(op),
        .A(a), .B(b), .Shamt(sh), .Busy(Busy), .Done(Done), .Zero(Zero),
        .Overflow(Overflow), .ALUResult(ALUResult), .HI(HI), .LO(LO),
        .dbg_state(dbg_state)
    );

    alu_mdu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .Start(s_start), .ALUOperation(s_op),
        .A(s_a), .B(s_b), .Shamt(s_sh), .Busy(s_busy), .Done(s_done), .Zero(s_zero),
        .Overflow(s_ovf), .ALUResult(s_res), .HI(s_hi), .LO(s_lo),
        .dbg_state(s_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=<empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic alu_op(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] s, input logic [31:0] exp_r,
                          input logic exp_z, input logic exp_ov, input string tag);
        @(negedge clk);
        op = o; a = av; b = bv; sh = s; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        exp_q.push_back(exp_r);
        check({tag, ".done"}, 32'(Done), 32'd1);
        check_q({tag, ".res"}, ALUResult);
        check({tag, ".zero"}, 32'(Zero), 32'(exp_z));
        check({tag, ".ovf"}, 32'(Overflow), 32'(exp_ov));
    endtask

    // inject > 0 pulses a stray ADD Start at that cycle while the unit is busy.
    task automatic run_mdu(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                           input int inject, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input logic [31:0] prev_res, input string tag);
        int busy_n = 0;
        int done_at = 0;
        @(negedge clk);
        op = o; a = av; b = bv; Start = 1'b1;
        for (int cyc = 1; cyc <= 80 && done_at == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                Start = 1'b0;
                a = $urandom();
                b = $urandom();
            end
            if (Busy) busy_n++;
            if (Done) done_at = cyc;
            if (cyc == 5) check({tag, ".hold"}, ALUResult, prev_res);
            if (cyc == inject) begin
                op = 5'd3; Start = 1'b1;
            end
            if (inject > 0 && cyc == inject + 1) Start = 1'b0;
        end
        Start = 1'b0;
        check({tag, ".done_cycle"}, 32'(done_at), 32'd34);
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'd33);
        check({tag, ".hi"}, HI, exp_hi);
        check({tag, ".lo"}, LO, exp_lo);
        check({tag, ".res_held"}, ALUResult, prev_res);
    endtask

    initial begin
        int done_seen;
        int s_busy_n;
        int s_done_at;
        reset = 1'b1; Start = 1'b0; op = '0; a = '0; b = '0; sh = '0;
        s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0; s_sh = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.busy", 32'(Busy), 32'd0);
        check("rst.done", 32'(Done), 32'd0);
        check("rst.zero", 32'(Zero), 32'd0);
        check("rst.ovf", 32'(Overflow), 32'd0);
        check("rst.res", ALUResult, 32'd0);
        check("rst.hi", HI, 32'd0);
        check("rst.lo", LO, 32'd0);
        check("rst.state", 32'(dbg_state), 32'd0);

        alu_op(5'd3, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        @(negedge clk);
        check("add_ovf.done_pulse", 32'(Done), 32'd0);
        alu_op(5'd4, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1, 1'b0, "sub_zero");
        alu_op(5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0, "and");
        alu_op(5'd10, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0, "sra");
        alu_op(5'd0, 32'h0, 32'h1, 5'd31, 32'h8000_0000, 1'b0, 1'b0, "sll");
        alu_op(5'd1, 32'h0, 32'h8000_0000, 5'd31, 32'h1, 1'b0, 1'b0, "srl");
        alu_op(5'd2, 32'h0, 32'h1234_ABCD, 5'd0, 32'hABCD_0000, 1'b0, 1'b0, "lui");
        alu_op(5'd7, 32'h0, 32'hFFFF_0000, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0, "nor");
        alu_op(5'd8, 32'h1234_0000, 32'h0000_5678, 5'd0, 32'h1234_5678, 1'b0, 1'b0, "or");
        alu_op(5'd4, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, "sub_ovf");
        alu_op(5'd11, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, "slt");
        alu_op(5'd12, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, "sltu");
        alu_op(5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0, 1'b1, 1'b0, "undef6");
        alu_op(5'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'hF00F_F00F, 1'b0, 1'b0, "xor");

        run_mdu(5'd16, 32'hFFFF_FFFD, 32'd7, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hF00F_F00F, "mult");
        alu_op(5'd13, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "mfhi");
        alu_op(5'd14, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFEB, 1'b0, 1'b0, "mflo");
        run_mdu(5'd18, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "div");
        run_mdu(5'd19, 32'd7, 32'd0, 0, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "divu_zero");
        run_mdu(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000, 32'hFFFF_FFEB, "div_minneg");
        run_mdu(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFEB, "multu_busy");
        alu_op(5'd14, 32'h0, 32'h0, 5'd0, 32'h1, 1'b0, 1'b0, "mflo2");

        @(negedge clk);
        op = 5'd18; a = 32'd100; b = 32'd7; Start = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (cyc == 1) Start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("rst_mid.busy", 32'(Busy), 32'd0);
        check("rst_mid.hi", HI, 32'd0);
        check("rst_mid.lo", LO, 32'd0);
        check("rst_mid.res", ALUResult, 32'd0);
        check("rst_mid.state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) done_seen = 1;
        end
        check("rst_mid.no_done", 32'(done_seen), 32'd0);
        alu_op(5'd3, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, "add_after_rst");

        s_busy_n = 0;
        s_done_at = 0;
        @(negedge clk);
        s_op = 5'd16; s_a = 16'hFFFD; s_b = 16'd7; s_start = 1'b1;
        for (int cyc = 1; cyc <= 60 && s_done_at == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) s_start = 1'b0;
            if (s_busy) s_busy_n++;
            if (s_done) s_done_at = cyc;
        end
        s_start = 1'b0;
        check("mult16.done_cycle", 32'(s_done_at), 32'd18);
        check("mult16.busy_cycles", 32'(s_busy_n), 32'd17);
        check("mult16.hi", 32'(s_hi), 32'h0000_FFFF);
        check("mult16.lo", 32'(s_lo), 32'h0000_FFEB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
